muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32M instructions, i.e. opcode R-type with funct7 = 0000001, as flagged by the R/M decode stage.
- Accepts an operation at EX entry, stalls the pipeline while an iterative shift-add multiplier or restoring divider runs, then presents the result and write-back controls for one cycle.
- Sits between ID/EX and the EX/MEM write-back mux; owns the stall request for M-extension ops.

---
 rtl/muldiv_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M multiply/divide sequencer that stalls the pipeline while an iterative datapath runs.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational product.
module muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] op1_in,
    input  logic [XLEN-1:0] op2_in,
    input  logic [4:0]      waddr_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            busy_out,
    output logic [XLEN-1:0] result_out,
    output logic            ready_out,
    output logic            reg_wenable_out,
    output logic [4:0]      reg_waddr_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic              neg_q;

    logic              abs1, abs2, sgn;
    logic [XLEN-1:0]   mag1, mag2;
    logic              is_div, div_zero, div_ovf, skip_calc;

    always_comb begin
        abs1 = 1'b0;
        abs2 = 1'b0;
        sgn  = 1'b0;
        case (funct3_in)
            F_MULH: begin
                abs1 = 1'b1;
                abs2 = 1'b1;
                sgn  = op1_in[XLEN-1] ^ op2_in[XLEN-1];
            end
            F_MULHSU: begin
                abs1 = 1'b1;
                sgn  = op1_in[XLEN-1];
            end
            F_DIV: begin
                abs1 = 1'b1;
                abs2 = 1'b1;
                sgn  = op1_in[XLEN-1] ^ op2_in[XLEN-1];
            end
            F_REM: begin
                abs1 = 1'b1;
                abs2 = 1'b1;
                sgn  = op1_in[XLEN-1];
            end
            default: ;
        endcase
    end

    assign mag1     = neg_word(op1_in, abs1 & op1_in[XLEN-1]);
    assign mag2     = neg_word(op2_in, abs2 & op2_in[XLEN-1]);
    assign is_div   = funct3_in[2];
    assign div_zero = is_div && (op2_in == '0);
    assign div_ovf  = is_div && !funct3_in[0] && (op1_in == INT_MIN) && (op2_in == '1);

    // Iteration step: acc holds {product_hi, multiplier} or {remainder, quotient}
    logic [XLEN:0]     mul_hi, trial;
    logic [2*XLEN-1:0] mul_step, div_step, acc_step;

    assign mul_hi   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_step = {mul_hi, acc[XLEN-1:1]};
    assign trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb};
    assign div_step = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign acc_step = f3_q[2] ? div_step : mul_step;

    logic [2*XLEN-1:0] raw_prod;
`ifdef MULDIV_FAST_MUL_EN
    assign skip_calc = ~funct3_in[2];
    assign raw_prod  = {{XLEN{1'b0}}, acc[XLEN-1:0]} * {{XLEN{1'b0}}, opb};
`else
    assign skip_calc = 1'b0;
    assign raw_prod  = acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            f3_q  <= '0;
            rd_q  <= '0;
            opb   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in && !flush_in) begin
                        f3_q <= funct3_in;
                        rd_q <= waddr_in;
                        opb  <= mag2;
                        cnt  <= '0;
                        if (div_zero) begin
                            acc   <= {op1_in, {XLEN{1'b1}}};
                            neg_q <= 1'b0;
                            state <= S_DONE;
                        end else if (div_ovf) begin
                            acc   <= {{XLEN{1'b0}}, INT_MIN};
                            neg_q <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, mag1};
                            neg_q <= sgn;
                            state <= skip_calc ? S_DONE : S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_in) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sign fix-up and result select during the ready cycle
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, sel;

    assign prod = neg_dword(raw_prod, neg_q);
    assign quo  = neg_word(acc[XLEN-1:0], neg_q);
    assign rem  = neg_word(acc[2*XLEN-1:XLEN], neg_q);

    always_comb begin
        sel = '0;
        case (f3_q)
            F_MUL:                    sel = prod[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: sel = prod[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:            sel = quo;
            default:                  sel = rem;
        endcase
    end

    assign busy_out        = (state != S_IDLE);
    assign stall_out       = ((state == S_IDLE) && start_in && !flush_in) || (state == S_CALC);
    assign ready_out       = (state == S_DONE) && !flush_in;
    assign reg_wenable_out = ready_out;
    assign reg_waddr_out   = ready_out ? rd_q : '0;
    assign result_out      = ready_out ? sel : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and randomized ops checked against an arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic [2:0]  funct3_in;
    logic [31:0] op1_in;
    logic [31:0] op2_in;
    logic [4:0]  waddr_in;
    logic        flush_in;
    logic        stall_out;
    logic        busy_out;
    logic [31:0] result_out;
    logic        ready_out;
    logic        reg_wenable_out;
    logic [4:0]  reg_waddr_out;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_ready_cyc = 0;

    muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_in        (start_in),
        .funct3_in       (funct3_in),
        .op1_in          (op1_in),
        .op2_in          (op2_in),
        .waddr_in        (waddr_in),
        .flush_in        (flush_in),
        .stall_out       (stall_out),
        .busy_out        (busy_out),
        .result_out      (result_out),
        .ready_out       (ready_out),
        .reg_wenable_out (reg_wenable_out),
        .reg_waddr_out   (reg_waddr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Called just after a rising edge of an idle cycle; returns just after the edge following DONE.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int          n;
        bit          got, stall_ok;
        logic [31:0] exp;
        exp = ref_result(f3, a, b);
        start_in = 1'b1; funct3_in = f3; op1_in = a; op2_in = b; waddr_in = rd;
        stall_ok = 1'b1; got = 1'b0; n = 0;
        @(negedge clk);
        if (!stall_out || ready_out || busy_out) stall_ok = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b0; op1_in = $urandom; op2_in = $urandom; waddr_in = 5'($urandom);
        funct3_in = 3'($urandom);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (ready_out) begin got = 1'b1; break; end
            if (!stall_out || !busy_out) stall_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " timeout"}, 64'(got), 64'd1);
        last_ready_cyc = cyc;
        chk({tag, " latency"}, 64'(n), 64'(ref_latency(f3, a, b)));
        chk({tag, " stall"}, 64'(stall_ok), 64'd1);
        chk({tag, " result"}, 64'(result_out), 64'(exp));
        chk({tag, " waddr"}, 64'(reg_waddr_out), 64'(rd));
        chk({tag, " wen/stall at done"}, {62'b0, reg_wenable_out, stall_out}, 64'b10);
        @(posedge clk); #1;
        chk({tag, " pulse end"}, {62'b0, ready_out, busy_out}, 64'b00);
    endtask

    initial begin
        int  r1;
        bit  seen;
        logic [2:0] f3;
        rst = 1'b0; start_in = 1'b0; funct3_in = '0; op1_in = '0; op2_in = '0;
        waddr_in = '0; flush_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset outputs", {result_out, 19'b0, stall_out, busy_out, ready_out,
                              reg_wenable_out, reg_waddr_out}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        do_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        do_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3);
        do_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        do_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        do_op("DIVU", 3'd5, 32'd100, 32'd7, 5'd7);
        do_op("REMU", 3'd7, 32'd100, 32'd7, 5'd8);
        do_op("DIVU by 0", 3'd5, 32'h1234, 32'd0, 5'd9);
        do_op("REMU by 0", 3'd7, 32'h1234, 32'd0, 5'd10);
        do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // Flush mid-divide, then a new op accepted on the next cycle.
        start_in = 1'b1; funct3_in = 3'd4; op1_in = 32'd1000; op2_in = 32'd3; waddr_in = 5'd13;
        repeat (10) begin @(posedge clk); #1; start_in = 1'b0; end
        flush_in = 1'b1;
        @(negedge clk);
        chk("flush ready", {62'b0, ready_out, reg_wenable_out}, 64'b00);
        @(posedge clk); #1;
        flush_in = 1'b0;
        chk("flush busy", 64'(busy_out), 64'd0);
        do_op("after flush", 3'd4, 32'hFFFF_FF00, 32'd5, 5'd14);

        // Flush during the ready cycle suppresses the write.
        start_in = 1'b1; funct3_in = 3'd5; op1_in = 32'h55; op2_in = 32'd0; waddr_in = 5'd15;
        @(posedge clk); #1;
        start_in = 1'b0; flush_in = 1'b1;
        @(negedge clk);
        chk("flush done wen", {62'b0, ready_out, reg_wenable_out}, 64'b00);
        chk("flush done result", 64'(result_out), 64'd0);
        @(posedge clk); #1;
        flush_in = 1'b0;
        chk("flush done busy", 64'(busy_out), 64'd0);

        // start together with flush in IDLE is not accepted.
        start_in = 1'b1; flush_in = 1'b1; funct3_in = 3'd0;
        @(negedge clk);
        chk("start+flush stall", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        start_in = 1'b0; flush_in = 1'b0;
        chk("start+flush busy", 64'(busy_out), 64'd0);

        // Asynchronous reset mid-multiply.
        start_in = 1'b1; funct3_in = 3'd0; op1_in = 32'd9; op2_in = 32'd9; waddr_in = 5'd16;
        repeat (5) begin @(posedge clk); #1; start_in = 1'b0; end
        rst = 1'b1;
        #1;
        chk("mid reset outputs", {result_out, 19'b0, stall_out, busy_out, ready_out,
                                  reg_wenable_out, reg_waddr_out}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (ready_out || reg_wenable_out) seen = 1'b1; end
        chk("no ready after reset", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Back-to-back multiplies.
        do_op("b2b first", 3'd0, 32'd123, 32'd456, 5'd17);
        r1 = last_ready_cyc;
        do_op("b2b second", 3'd0, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd18);
        chk("b2b spacing", 64'(last_ready_cyc - r1), 64'(MUL_LAT + 1));

        for (int i = 0; i < 50; i++) begin
            f3 = 3'($urandom);
            do_op("rand", f3, pick_operand(), pick_operand(), 5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
